store_buffer_ctrl: RTL and testbench
====================================

Name: store_buffer_ctrl

Overview:
Posted-store buffer and data-memory port scheduler between the MEM stage and the single data-memory port. Stores in MEM are queued in a small FIFO and drained in the background. Loads share the port with the drain traffic. The block arbitrates the port, detects load-after-buffered-store address hazards and fences, and drives the pipeline stall for the MEM stage.

Parameters:
DEPTH, 4, store buffer entries (power of two, at least 2)
ADDR_W, 32, byte address width
DATA_W, 32, store/load data width; byte mask width is DATA_W/8

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
memaccess_m  in  memaccess_t  MEM-stage access type (MEM_READ / MEM_WRITE / none)
fence_m  in  1  MEM-stage instruction is a FENCE
addr_m  in  ADDR_W  MEM-stage byte address
wdata_m  in  DATA_W  store data, already forwarded
wmask_m  in  DATA_W/8  store byte enables
stall_m  out  1  hold the MEM stage and everything upstream this cycle
load_done  out  1  load accepted by memory this cycle; mem_rdata is valid
mem_req  out  1  port request valid
mem_we  out  1  1 = write (drain), 0 = read (load)
mem_addr  out  ADDR_W  port address
mem_wdata  out  DATA_W  port write data
mem_wmask  out  DATA_W/8  port byte enables
mem_ready  in  1  memory accepts the request this cycle; read data returns the same cycle
count  out  $clog2(DEPTH)+1  occupied entries, for debug/perf

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset: pointers = 0, count = 0, all entries invalid, FSM = RUN.
  - Combinational outputs settle to mem_req = 0, stall_m = 0, load_done = 0 with no access in MEM.
  - Reset mid-drain discards buffered stores with no memory write; the top level accepts this.
- FIFO storage: {word address = addr_m[ADDR_W-1:2] plus byte offset, wdata, wmask}.
  - Head and tail pointers wrap modulo DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Hazard: a load is hazarded when any valid entry's addr[ADDR_W-1:2] equals addr_m[ADDR_W-1:2]. Byte masks are ignored, so the check is conservative. There is no data forwarding from the buffer.
- Arbitration, evaluated combinationally each cycle, in priority order:
  1. FSM = FENCE, or full → drain head.
  2. Unhazarded load in MEM → load request (mem_we = 0, addr_m).
  3. !empty → drain head (mem_we = 1, head fields).
  4. Otherwise mem_req = 0.
- Drain completes when mem_req && mem_we && mem_ready: pop head, head+1.
- Store enqueue: memaccess_m == MEM_WRITE && !full → push at tail in that cycle, with no stall.
  - A store while full stalls, even if a drain completes in the same cycle. There is no same-cycle pass-through; the store enqueues next cycle.
  - A push and a pop in the same cycle leave count unchanged.
- stall_m = 1 when any of:
  - store && full;
  - load && (hazard || !(load granted && mem_ready));
  - fence_m && !empty.
- load_done = load granted && mem_ready.
- FSM:
  - RUN → FENCE when fence_m && !empty.
  - FENCE → RUN when the cycle pops the last entry (count goes 1→0). fence_m is released (stall_m = 0) in the first cycle with empty = 1.
  - A fence with the buffer already empty causes no stall and no transition.
- Requests are stable until accepted: once mem_req is raised for a drain, head fields do not change until mem_ready.
  - A load that appears while a drain is waiting on mem_ready preempts it only when not full and not in FENCE; this is permitted because no transfer has occurred.

Decomposition:
- Shared package riscv_defines:
  - reuse memaccess_t;
  - add sb_entry_t (addr, data, mask);
  - add sb_state_t {SB_RUN, SB_FENCE};
  - add SB_DEPTH default constant.
- Sub-module sb_fifo: storage array, pointers and count, plus a per-entry address compare vector output. It is instantiated once.
- The arbiter, stall and FSM logic live in store_buffer_ctrl.

Test Plan:
1. Four back-to-back stores to 0x100/0x104/0x108/0x10C with mem_ready = 0 → no stall, count = 4. A fifth store → stall_m = 1. Then mem_ready = 1 → 0x100 drains first and the fifth store enqueues the next cycle.
2. Store 0x200 = 0xDEADBEEF buffered, then load 0x202 with mem_ready = 1 → stall_m = 1 until 0x200 is written. Then a load request at 0x202 occurs and load_done = 1.
3. Store 0x300 buffered, load 0x400 with mem_ready = 1 → load granted ahead of the drain, load_done = 1, stall_m = 0, count stays 1.
4. Three stores buffered, fence_m = 1, mem_ready random → stall_m = 1 until count = 0. Writes occur in FIFO order. FSM returns to RUN.
5. Store push and drain pop in the same cycle with count = 2 → count stays 2 and pointers wrap correctly across the DEPTH boundary (check 10 cycles).
6. rst_n = 0 for one cycle with count = 3 and a drain pending → next cycle count = 0, mem_req = 0, stall_m = 0.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared pipeline definitions: memory access kinds and store-buffer types.
package riscv_defines;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } memaccess_t;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-1:0]   addr;
        logic [SB_DATA_W-1:0]   data;
        logic [SB_DATA_W/8-1:0] mask;
    } sb_entry_t;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_FENCE = 1'b1
    } sb_state_t;

endpackage

// File: rtl/store_buffer_ctrl_fifo.sv
// Store-buffer storage: circular FIFO of posted stores with a per-entry
// word-address compare vector used for load hazard detection.
module sb_fifo
    import riscv_defines::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic [ADDR_W-1:0]   i_push_addr,
    input  logic [DATA_W-1:0]   i_push_data,
    input  logic [DATA_W/8-1:0] i_push_mask,
    input  logic [ADDR_W-1:0]   i_cmp_addr,
    output logic [ADDR_W-1:0]   o_head_addr,
    output logic [DATA_W-1:0]   o_head_data,
    output logic [DATA_W/8-1:0] o_head_mask,
    output logic [CNT_W-1:0]    o_count,
    output logic                o_full,
    output logic                o_empty,
    output logic [DEPTH-1:0]    o_match
);

    logic [ADDR_W-1:0]   r_addr [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [DATA_W/8-1:0] r_mask [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (i_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_tail] <= i_push_addr;
            r_data[r_tail] <= i_push_data;
            r_mask[r_tail] <= i_push_mask;
        end
    end

    always_comb begin
        o_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_match[i] = r_valid[i] && (r_addr[i][ADDR_W-1:2] == i_cmp_addr[ADDR_W-1:2]);
        end
    end

    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_head_mask = r_mask[r_head];
    assign o_count     = r_count;
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);

endmodule

// File: rtl/store_buffer_ctrl.sv
// Posted-store buffer and data-memory port scheduler for the MEM stage:
// arbitrates loads against background drains, detects hazards, handles fences.
module store_buffer_ctrl
    import riscv_defines::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  memaccess_t            memaccess_m,
    input  logic                  fence_m,
    input  logic [ADDR_W-1:0]     addr_m,
    input  logic [DATA_W-1:0]     wdata_m,
    input  logic [DATA_W/8-1:0]   wmask_m,
    output logic                  stall_m,
    output logic                  load_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_ready,
    output logic [$clog2(DEPTH):0] count
);

    sb_state_t             r_state;
    logic                  w_is_load;
    logic                  w_is_store;
    logic                  w_hazard;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_sel_load;
    logic                  w_sel_drain;
    logic [DEPTH-1:0]      w_match;
    logic [ADDR_W-1:0]     w_head_addr;
    logic [DATA_W-1:0]     w_head_data;
    logic [DATA_W/8-1:0]   w_head_mask;
    logic [$clog2(DEPTH):0] w_count;

    assign w_is_load  = (memaccess_m == MEM_READ);
    assign w_is_store = (memaccess_m == MEM_WRITE);
    assign w_hazard   = w_is_load && (|w_match);

    // A store arriving while full waits a cycle even if a drain frees a slot now.
    assign w_push = w_is_store && !w_full;
    assign w_pop  = w_sel_drain && mem_ready;

    sb_fifo #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_push_addr(addr_m),
        .i_push_data(wdata_m),
        .i_push_mask(wmask_m),
        .i_cmp_addr (addr_m),
        .o_head_addr(w_head_addr),
        .o_head_data(w_head_data),
        .o_head_mask(w_head_mask),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_match    (w_match)
    );

    always_comb begin
        w_sel_load  = 1'b0;
        w_sel_drain = 1'b0;
        if (((r_state == SB_FENCE) || w_full) && !w_empty) begin
            w_sel_drain = 1'b1;
        end else if (w_is_load && !w_hazard) begin
            w_sel_load = 1'b1;
        end else if (!w_empty) begin
            w_sel_drain = 1'b1;
        end
    end

    assign mem_req   = w_sel_load || w_sel_drain;
    assign mem_we    = w_sel_drain;
    assign mem_addr  = w_sel_load ? addr_m : w_head_addr;
    assign mem_wdata = w_head_data;
    assign mem_wmask = w_sel_load ? '0 : w_head_mask;
    assign load_done = w_sel_load && mem_ready;
    assign count     = w_count;

    assign stall_m = (w_is_store && w_full)
                   || (w_is_load && !(w_sel_load && mem_ready))
                   || (fence_m && !w_empty);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SB_RUN;
        end else begin
            case (r_state)
                SB_RUN:   if (fence_m && !w_empty) r_state <= SB_FENCE;
                SB_FENCE: if (w_pop && !w_push && (w_count == 1)) r_state <= SB_RUN;
                default:  r_state <= SB_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Scoreboard bench for store_buffer_ctrl: memory writes are checked in order
// against stores accepted from the MEM stage; loads/stalls checked directly.
module tb_store_buffer_ctrl;
    import riscv_defines::*;

    logic        clk = 1'b0;
    logic        rst_n;
    memaccess_t  memaccess_m;
    logic        fence_m;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    logic [3:0]  wmask_m;
    logic        stall_m;
    logic        load_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready;
    logic [2:0]  count;

    always #5 clk = ~clk;

    store_buffer_ctrl #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .memaccess_m(memaccess_m),
        .fence_m    (fence_m),
        .addr_m     (addr_m),
        .wdata_m    (wdata_m),
        .wmask_m    (wmask_m),
        .stall_m    (stall_m),
        .load_done  (load_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_ready  (mem_ready),
        .count      (count)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  n_checks = 0;
    int  n_errors = 0;
    int  n_before;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: compare drains, then record stores accepted this cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (mem_req && mem_we && mem_ready) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(e.a));
                    chk("wr_data", 64'(mem_wdata), 64'(e.d));
                    chk("wr_mask", 64'(mem_wmask), 64'(e.m));
                end
            end
            if (memaccess_m == MEM_WRITE && !stall_m)
                exp_q.push_back('{addr_m, wdata_m, wmask_m});
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memaccess_m = MEM_NONE;
        fence_m     = 1'b0;
        addr_m      = '0;
        wdata_m     = '0;
        wmask_m     = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        memaccess_m = MEM_WRITE;
        fence_m     = 1'b0;
        addr_m      = a;
        wdata_m     = d;
        wmask_m     = m;
    endtask

    task automatic load(input logic [31:0] a);
        memaccess_m = MEM_READ;
        fence_m     = 1'b0;
        addr_m      = a;
        wdata_m     = '0;
        wmask_m     = '0;
    endtask

    task automatic buffer_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        store(a, d, m);
        @(negedge clk);
        chk("buf_nostall", 64'(stall_m), 64'd0);
        next();
    endtask

    task automatic drain(input string tag);
        idle();
        mem_ready = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) next();
        @(negedge clk);
        chk({tag, "_count0"}, 64'(count), 64'd0);
        chk({tag, "_sbq0"}, 64'(exp_q.size()), 64'd0);
        mem_ready = 1'b0;
        next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_stall", 64'(stall_m), 64'd0);
        chk("rst_ldone", 64'(load_done), 64'd0);
        next();

        // 1: fill, stall on full, drain frees a slot for next-cycle enqueue
        for (int i = 0; i < 4; i++) buffer_store(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
        store(32'h110, 32'hA000_0004, 4'hF);
        @(negedge clk);
        chk("t1_count4", 64'(count), 64'd4);
        chk("t1_full_stall", 64'(stall_m), 64'd1);
        next();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t1_stall_drain", 64'(stall_m), 64'd1);
        chk("t1_head_addr", 64'(mem_addr), 64'h100);
        chk("t1_head_we", 64'(mem_we), 64'd1);
        next();
        @(negedge clk);
        chk("t1_enq_nostall", 64'(stall_m), 64'd0);
        chk("t1_count3", 64'(count), 64'd3);
        next();
        drain("t1");

        // 2: hazarded load waits for the matching word to drain
        buffer_store(32'h200, 32'hDEAD_BEEF, 4'hF);
        load(32'h202);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t2_haz_stall", 64'(stall_m), 64'd1);
        chk("t2_haz_we", 64'(mem_we), 64'd1);
        chk("t2_haz_addr", 64'(mem_addr), 64'h200);
        chk("t2_haz_ldone", 64'(load_done), 64'd0);
        next();
        @(negedge clk);
        chk("t2_ld_we", 64'(mem_we), 64'd0);
        chk("t2_ld_addr", 64'(mem_addr), 64'h202);
        chk("t2_ld_done", 64'(load_done), 64'd1);
        chk("t2_ld_stall", 64'(stall_m), 64'd0);
        next();
        drain("t2");

        // 3: unhazarded load bypasses a pending drain
        mem_ready = 1'b0;
        buffer_store(32'h300, 32'h3333_3333, 4'h5);
        load(32'h400);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t3_ld_we", 64'(mem_we), 64'd0);
        chk("t3_ld_addr", 64'(mem_addr), 64'h400);
        chk("t3_ld_done", 64'(load_done), 64'd1);
        chk("t3_ld_stall", 64'(stall_m), 64'd0);
        next();
        idle();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("t3_count1", 64'(count), 64'd1);
        next();
        drain("t3");

        // 4: fence holds MEM until the buffer is empty, random memory backpressure
        buffer_store(32'h500, 32'h5555_0000, 4'h3);
        buffer_store(32'h504, 32'h5555_0004, 4'hC);
        buffer_store(32'h508, 32'h5555_0008, 4'h1);
        idle();
        fence_m  = 1'b1;
        n_before = exp_q.size();
        for (int i = 0; i < 100; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            n_before  = exp_q.size();
            @(negedge clk);
            chk("t4_fence_stall", 64'(stall_m), 64'(n_before != 0));
            if (n_before == 0) break;
            next();
        end
        chk("t4_fence_done", 64'(n_before), 64'd0);
        next();
        idle();
        mem_ready = 1'b0;
        buffer_store(32'h600, 32'h6666_6666, 4'hF);
        load(32'h700);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t4_run_ldone", 64'(load_done), 64'd1);
        next();
        drain("t4");

        // 5: steady push+pop with two entries, pointers wrap several times
        mem_ready = 1'b0;
        buffer_store(32'h800, 32'h8000_0000, 4'hF);
        buffer_store(32'h804, 32'h8000_0001, 4'hE);
        mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            store(32'h808 + 32'(4 * k), 32'h8800_0000 + 32'(k), 4'(k + 1));
            @(negedge clk);
            chk("t5_count2", 64'(count), 64'd2);
            chk("t5_nostall", 64'(stall_m), 64'd0);
            next();
        end
        drain("t5");

        // 6: reset with stores buffered discards them
        mem_ready = 1'b0;
        buffer_store(32'h900, 32'h9000_0000, 4'hF);
        buffer_store(32'h904, 32'h9000_0001, 4'hF);
        buffer_store(32'h908, 32'h9000_0002, 4'hF);
        idle();
        @(negedge clk);
        chk("t6_count3", 64'(count), 64'd3);
        chk("t6_req_pend", 64'(mem_req), 64'd1);
        next();
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_count0", 64'(count), 64'd0);
        chk("t6_req0", 64'(mem_req), 64'd0);
        chk("t6_stall0", 64'(stall_m), 64'd0);
        next();
        buffer_store(32'hA00, 32'hAAAA_5555, 4'h9);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
